// File: rtl/bus_sram_slave.sv
// Burst SRAM slave on the system bus: windowed decode, read/write bursts.
// Define BUS_SRAM_BUSY_THROTTLE_EN to insert a busy cycle every 4 write beats.
module bus_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int ADDR_WIDTH = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [31:0] addressDataIn,
  output logic        endTransactionOut,
  output logic        dataValidOut,
  output logic        busyOut,
  output logic        busErrorOut,
  output logic [31:0] addressDataOut
);

  typedef enum logic [2:0] {
    IDLE,
    READ_FETCH,
    READ_BURST,
    READ_END,
    WRITE,
    ERROR
  } state_t;

  state_t state, stateN;

  logic                  rnw, rnwN;
  logic [3:0]            be, beN;
  logic [7:0]            count, countN;
  logic [ADDR_WIDTH-1:0] index, indexN;
  logic                  exhausted, exhaustedN;
  logic                  endN, validN, errorN;
  logic                  loadData;
  logic                  accept, wrEn;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] startIndex;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  assign hit = addressDataIn[31:ADDR_WIDTH+2]
            == BASE_ADDR[31:ADDR_WIDTH+2];
  assign startIndex = addressDataIn[ADDR_WIDTH+1:2];

  // Beats past the burst length are accepted but never reach the array
  assign accept = (state == WRITE) && dataValidIn && !busyOut;
  assign wrEn = accept && !exhausted;

  always_comb begin
    stateN     = state;
    rnwN       = rnw;
    beN        = be;
    countN     = count;
    indexN     = index;
    exhaustedN = exhausted;
    endN       = 1'b0;
    validN     = 1'b0;
    errorN     = 1'b0;
    loadData   = 1'b0;
    unique case (state)
      IDLE: begin
        if (beginTransactionIn) begin
          rnwN       = readNotWriteIn;
          beN        = byteEnablesIn;
          countN     = burstSizeIn;
          indexN     = startIndex;
          exhaustedN = 1'b0;
          if (!hit) begin
            stateN = ERROR;
            errorN = 1'b1;
          end else if (readNotWriteIn) begin
            stateN = READ_FETCH;
          end else begin
            stateN = WRITE;
          end
        end
      end
      READ_FETCH: begin
        loadData = 1'b1;
        validN   = 1'b1;
        indexN   = index + 1'b1;
        stateN   = READ_BURST;
      end
      READ_BURST: begin
        if (count == 8'd0) begin
          stateN = READ_END;
          endN   = 1'b1;
        end else begin
          loadData = 1'b1;
          validN   = 1'b1;
          indexN   = index + 1'b1;
          countN   = count - 8'd1;
        end
      end
      READ_END: begin
        stateN = IDLE;
      end
      WRITE: begin
        if (wrEn) begin
          if (count == 8'd0) begin
            exhaustedN = 1'b1;
          end else begin
            countN = count - 8'd1;
            indexN = index + 1'b1;
          end
        end
        if (endTransactionIn) stateN = IDLE;
      end
      ERROR: begin
        if (rnw) begin
          stateN = READ_END;
          endN   = 1'b1;
        end else if (endTransactionIn) begin
          stateN = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      rnw               <= 1'b0;
      be                <= 4'd0;
      count             <= 8'd0;
      index             <= '0;
      exhausted         <= 1'b0;
      endTransactionOut <= 1'b0;
      dataValidOut      <= 1'b0;
      busErrorOut       <= 1'b0;
      addressDataOut    <= 32'd0;
    end else begin
      state             <= stateN;
      rnw               <= rnwN;
      be                <= beN;
      count             <= countN;
      index             <= indexN;
      exhausted         <= exhaustedN;
      endTransactionOut <= endN;
      dataValidOut      <= validN;
      busErrorOut       <= errorN;
      addressDataOut    <= loadData ? mem[index] : 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= addressDataIn[8*i +: 8];
      end
    end
  end

`ifdef BUS_SRAM_BUSY_THROTTLE_EN
  logic [1:0] beatCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beatCount <= 2'd0;
      busyOut   <= 1'b0;
    end else begin
      busyOut <= accept && (beatCount == 2'd3);
      if (state != WRITE) beatCount <= 2'd0;
      else if (accept) beatCount <= beatCount + 2'd1;
    end
  end
`else
  assign busyOut = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: bursts, byte lanes, wrap, errors,
// async reset and (when BUS_SRAM_BUSY_THROTTLE_EN is set) write throttling.
module tb_bus_sram_slave;

`ifdef BUS_SRAM_BUSY_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        beginT;
  logic        endT;
  logic        rnw;
  logic        dv;
  logic [3:0]  be;
  logic [7:0]  burst;
  logic [31:0] adIn;
  logic        endOut;
  logic        dvOut;
  logic        busy;
  logic        busErr;
  logic [31:0] adOut;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] expv [0:15];
  logic [31:0] wdat [0:15];

  bus_sram_slave dut (
    .clock(clock),
    .reset(reset),
    .beginTransactionIn(beginT),
    .endTransactionIn(endT),
    .readNotWriteIn(rnw),
    .dataValidIn(dv),
    .byteEnablesIn(be),
    .burstSizeIn(burst),
    .addressDataIn(adIn),
    .endTransactionOut(endOut),
    .dataValidOut(dvOut),
    .busyOut(busy),
    .busErrorOut(busErr),
    .addressDataOut(adOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic writeBurst(input logic [31:0] addr,
                            input logic [3:0] ben,
                            input logic [7:0] bsz,
                            input int n);
    int i;
    int acc;
    int guard;
    logic ok;
    beginT = 1'b1;
    rnw    = 1'b0;
    be     = ben;
    burst  = bsz;
    adIn   = addr;
    tick();
    beginT = 1'b0;
    i = 0;
    acc = 0;
    guard = 0;
    while (i < n && guard < 64) begin
      dv   = 1'b1;
      adIn = wdat[i];
      ok   = !busy;
      tick();
      guard++;
      if (ok) begin
        i++;
        acc++;
        check("wr-busy", 32'(busy), 32'(THR && (acc % 4 == 0)));
      end
    end
    if (guard >= 64) check("wr-timeout", i, n);
    dv   = 1'b0;
    adIn = 32'd0;
    endT = 1'b1;
    tick();
    endT = 1'b0;
    tick();
  endtask

  task automatic readCheck(input logic [31:0] addr,
                           input logic [7:0] bsz,
                           input string tag);
    beginT = 1'b1;
    rnw    = 1'b1;
    be     = 4'd0;
    burst  = bsz;
    adIn   = addr;
    tick();
    beginT = 1'b0;
    adIn   = 32'd0;
    check({tag, "-fetch-dv"}, 32'(dvOut), 32'd0);
    check({tag, "-fetch-err"}, 32'(busErr), 32'd0);
    tick();
    for (int i = 0; i <= int'(bsz); i++) begin
      check({tag, "-dv"}, 32'(dvOut), 32'd1);
      check({tag, "-data"}, adOut, expv[i]);
      check({tag, "-noend"}, 32'(endOut), 32'd0);
      tick();
    end
    check({tag, "-end"}, 32'(endOut), 32'd1);
    check({tag, "-enddv"}, 32'(dvOut), 32'd0);
    check({tag, "-enddata"}, adOut, 32'd0);
    tick();
    check({tag, "-endgone"}, 32'(endOut), 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    beginT = 1'b0;
    endT   = 1'b0;
    rnw    = 1'b0;
    dv     = 1'b0;
    be     = 4'd0;
    burst  = 8'd0;
    adIn   = 32'd0;
    tick();
    tick();
    check("rst-end", 32'(endOut), 32'd0);
    check("rst-dv", 32'(dvOut), 32'd0);
    check("rst-busy", 32'(busy), 32'd0);
    check("rst-err", 32'(busErr), 32'd0);
    check("rst-data", adOut, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // preload words 0..3, then a 4-word read burst
    wdat[0] = 32'h11; wdat[1] = 32'h22;
    wdat[2] = 32'h33; wdat[3] = 32'h44;
    writeBurst(32'h4000_0000, 4'hF, 8'd3, 4);
    expv[0] = 32'h11; expv[1] = 32'h22;
    expv[2] = 32'h33; expv[3] = 32'h44;
    readCheck(32'h4000_0000, 8'd3, "rd4");

    // byte-lane write over zeroed words 4,5
    wdat[0] = 32'd0; wdat[1] = 32'd0;
    writeBurst(32'h4000_0010, 4'hF, 8'd1, 2);
    wdat[0] = 32'hAABB_CCDD; wdat[1] = 32'h1122_3344;
    writeBurst(32'h4000_0010, 4'b0011, 8'd1, 2);
    expv[0] = 32'h0000_CCDD; expv[1] = 32'h0000_3344;
    readCheck(32'h4000_0010, 8'd1, "be");

    // wrap from word 511 to word 0
    wdat[0] = 32'h5; wdat[1] = 32'h6;
    writeBurst(32'h4000_07FC, 4'hF, 8'd1, 2);
    expv[0] = 32'h5; expv[1] = 32'h6;
    readCheck(32'h4000_07FC, 8'd1, "wrap");

    // extra beat past burst length is dropped
    wdat[0] = 32'hA8; wdat[1] = 32'hA9;
    writeBurst(32'h4000_0020, 4'hF, 8'd1, 2);
    wdat[0] = 32'hBEEF; wdat[1] = 32'hDEAD;
    writeBurst(32'h4000_0020, 4'hF, 8'd0, 2);
    expv[0] = 32'hBEEF; expv[1] = 32'hA9;
    readCheck(32'h4000_0020, 8'd1, "drop");

    // out-of-window read
    beginT = 1'b1; rnw = 1'b1; burst = 8'd7;
    adIn = 32'h5000_0000;
    tick();
    beginT = 1'b0; adIn = 32'd0;
    check("erd-err", 32'(busErr), 32'd1);
    check("erd-dv", 32'(dvOut), 32'd0);
    check("erd-noend", 32'(endOut), 32'd0);
    tick();
    check("erd-errgone", 32'(busErr), 32'd0);
    check("erd-end", 32'(endOut), 32'd1);
    check("erd-dv2", 32'(dvOut), 32'd0);
    tick();
    check("erd-endgone", 32'(endOut), 32'd0);

    // out-of-window write; aliases word 0 if wrongly written
    beginT = 1'b1; rnw = 1'b0; be = 4'hF; burst = 8'd1;
    adIn = 32'h5000_0000;
    tick();
    beginT = 1'b0;
    check("ewr-err", 32'(busErr), 32'd1);
    dv = 1'b1; adIn = 32'hFFFF_FFFF;
    tick();
    check("ewr-errgone", 32'(busErr), 32'd0);
    tick();
    dv = 1'b0; adIn = 32'd0; endT = 1'b1;
    tick();
    endT = 1'b0;
    tick();
    check("ewr-err3", 32'(busErr), 32'd0);
    expv[0] = 32'h6;
    readCheck(32'h4000_0003, 8'd0, "ewr-after");

    // async reset during a read burst
    beginT = 1'b1; rnw = 1'b1; burst = 8'd7;
    adIn = 32'h4000_0000;
    tick();
    beginT = 1'b0; adIn = 32'd0;
    tick();
    tick();
    check("mid-dv", 32'(dvOut), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst-end", 32'(endOut), 32'd0);
    check("arst-dv", 32'(dvOut), 32'd0);
    check("arst-busy", 32'(busy), 32'd0);
    check("arst-err", 32'(busErr), 32'd0);
    check("arst-data", adOut, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    expv[0] = 32'h6;  expv[1] = 32'h22;
    expv[2] = 32'h33; expv[3] = 32'h44;
    readCheck(32'h4000_0000, 8'd3, "post-rst");

    // 8-beat write; throttled builds insert busy after beats 4 and 8
    for (int k = 0; k < 8; k++) begin
      wdat[k] = 32'h100 + 32'(k);
      expv[k] = 32'h100 + 32'(k);
    end
    writeBurst(32'h4000_0040, 4'hF, 8'd7, 8);
    readCheck(32'h4000_0040, 8'd7, "wr8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_sram_slave.md
Name: bus_sram_slave

Overview:
- Burst-capable on-chip SRAM slave on the shared system bus.
- Serves as the source and sink for the DMA custom-instruction block. DMA-in bursts read from it; DMA-out bursts write to it.
- Decodes a fixed address window. Returns read bursts one word per cycle, accepts write bursts with byte enables, and flags out-of-window accesses with busError.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte base address of the window; must be aligned to window size.
- ADDR_WIDTH, 9, word-address bits; window = 2^ADDR_WIDTH words (default 512 words = 2 KiB).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- beginTransactionIn  in  1  one-cycle transaction start; address on addressDataIn
- endTransactionIn  in  1  master ends a write (or error) transaction
- readNotWriteIn  in  1  sampled with beginTransactionIn; 1 = read
- dataValidIn  in  1  write data valid on addressDataIn
- byteEnablesIn  in  4  sampled with beginTransactionIn; lane enables for writes
- burstSizeIn  in  8  sampled with beginTransactionIn; words = burstSizeIn+1
- addressDataIn  in  32  address (begin cycle) / write data
- endTransactionOut  out  1  slave ends a read transaction
- dataValidOut  out  1  read data valid
- busyOut  out  1  slave cannot accept write data this cycle
- busErrorOut  out  1  access outside window
- addressDataOut  out  32  read data; 0 when dataValidOut=0

Behaviour:
- All outputs registered. Reset (async, active-low) forces state IDLE, all outputs 0, and counters 0. SRAM contents are not reset. Reset mid-burst aborts the burst silently.
- Hit: addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]. Word index = addressDataIn[ADDR_WIDTH+1:2]; bits [1:0] ignored.
- Only the start address is checked. The word index increments mod 2^ADDR_WIDTH, so a burst wraps inside the window.
- States: IDLE, READ_FETCH, READ_BURST, READ_END, WRITE, ERROR.
- IDLE:
  - On beginTransactionIn, latch rnw, byte enables, and remaining count = burstSizeIn.
  - Miss -> ERROR. Hit and read -> READ_FETCH. Hit and write -> WRITE.
  - beginTransactionIn in any other state is ignored.
- READ_FETCH: one cycle for synchronous SRAM read of the first word -> READ_BURST.
- READ_BURST:
  - dataValidOut=1 with a new word every cycle; first word 2 cycles after the begin cycle.
  - Count decrements each word. After the last word (count==0) -> READ_END.
- READ_END: endTransactionOut=1 for exactly one cycle, the cycle after the last dataValidOut -> IDLE.
- WRITE:
  - Each cycle with dataValidIn=1 and busyOut=0 writes addressDataIn to the current index under latched byte enables, then increments the index.
  - Beats beyond burstSizeIn+1 are dropped without increment.
  - endTransactionIn -> IDLE. A beat coinciding with endTransactionIn is still written.
- ERROR:
  - busErrorOut=1 for one cycle (the cycle after begin).
  - For reads: endTransactionOut=1 in the following cycle, then IDLE.
  - For writes: stay until endTransactionIn, then IDLE. No SRAM write occurs.
- busyOut=0 at all times unless the optional feature is enabled.
- byteEnablesIn is ignored for reads; full words are returned.

Optional Feature:
- Macro BUS_SRAM_BUSY_THROTTLE_EN.
- Defined: in WRITE, busyOut=1 for one cycle after every 4th accepted beat. Beats presented while busyOut=1 are not written, and the master must hold them. This stresses the DMA busy path.
- Undefined: busyOut tied 0; no throttle logic synthesised.

Test Plan:
- Read burst: preload words 0..3 = 0x11,0x22,0x33,0x44. Begin read @0x4000_0000, burstSize=3, at cycle T. Required: dataValidOut at T+2..T+5 carrying 0x11..0x44, endTransactionOut at T+6 only, busErrorOut=0.
- Write burst with byte enables: begin write @0x4000_0010, be=4'b0011, burst=1. Beats 0xAABBCCDD, 0x11223344, then endTransactionIn. Required: words 4,5 = 0x0000CCDD, 0x00003344 (from zero preload).
- Wrap: write burst of 2 at word 511 with 0x5, 0x6. Required: word511=0x5, word0=0x6.
- Error: begin read @0x5000_0000, burst=7. Required: busErrorOut at T+1, endTransactionOut at T+2, no dataValidOut. Begin write there: busErrorOut once, SRAM unchanged, IDLE after endTransactionIn.
- Reset mid-read: assert reset during READ_BURST of 8 words. Required: all outputs 0 immediately (async). After release, a new read @0x4000_0000 returns correct data.
- Throttle (macro defined): 8-beat write. Required: busyOut high after beats 4 and 8; all 8 words written correctly when the master holds data while busy.
